// File: rtl/decoder_stage_controller_pkg.sv
// Shared stage codes and state encoding for the union-find decoder sequencer.
// Stage codes match what every processing_unit decodes on stage_in.
package decoder_stage_controller_pkg;

  localparam int unsigned STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SPREAD_CLUSTER      = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW_BOUNDARY       = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_SYNC_IS_ODD_CLUSTER = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd4;

  // State encoding reuses the stage codes so stage_out is a direct copy of the state
  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE   = STAGE_IDLE,
    ST_SPREAD = STAGE_SPREAD_CLUSTER,
    ST_GROW   = STAGE_GROW_BOUNDARY,
    ST_SYNC   = STAGE_SYNC_IS_ODD_CLUSTER,
    ST_LOAD   = STAGE_MEASUREMENT_LOADING,
    ST_DONE   = 3'd5
  } state_t;

  function automatic logic [STAGE_WIDTH-1:0] stage_of(input state_t s);
    return (s == ST_DONE) ? STAGE_IDLE : STAGE_WIDTH'(s);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/decoder_stage_controller_reducer.sv
// Registered OR-reduction of the per-PU status vectors (one cycle latency).
module pu_status_reducer #(
  parameter int unsigned PU_COUNT = 100
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PU_COUNT-1:0] pu_is_processing,
  input  logic [PU_COUNT-1:0] pu_is_odd_cluster,
  output logic                any_processing,
  output logic                any_odd
);

  always_ff @(posedge clk) begin
    if (reset) begin
      any_processing <= 1'b0;
      any_odd        <= 1'b0;
    end else begin
      any_processing <= |pu_is_processing;
      any_odd        <= |pu_is_odd_cluster;
    end
  end

endmodule

// File: rtl/decoder_stage_controller.sv
// Central stage sequencer for the union-find PU array: load, then grow/spread/sync
// rounds until no odd cluster remains or the round limit is reached.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int unsigned CODE_DISTANCE           = 5,
  parameter int unsigned ITERATION_COUNTER_WIDTH = 8,
  parameter int unsigned MAX_ITERATION           = 10,
  parameter int unsigned SPREAD_SETTLE_CYCLES    = 3,
  parameter int unsigned SYNC_CYCLES             = 2,
  localparam int unsigned PU_COUNT = CODE_DISTANCE * CODE_DISTANCE * (CODE_DISTANCE - 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [PU_COUNT-1:0]                pu_is_processing,
  input  logic [PU_COUNT-1:0]                pu_is_odd_cluster,
  output logic [STAGE_WIDTH-1:0]             stage_out,
  output logic                               busy,
  output logic                               done,
  output logic                               timeout,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_count
);

  localparam int unsigned SETTLE_W = cnt_width(SPREAD_SETTLE_CYCLES);
  localparam int unsigned SYNC_W   = cnt_width(SYNC_CYCLES);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SPREAD_SETTLE_CYCLES - 1);
  localparam logic [SYNC_W-1:0]   SYNC_LAST   = SYNC_W'(SYNC_CYCLES - 1);
  localparam logic [ITERATION_COUNTER_WIDTH-1:0] ITER_MAX =
    ITERATION_COUNTER_WIDTH'(MAX_ITERATION);

  state_t                               state, state_n;
  logic [SETTLE_W-1:0]                  settle, settle_n;
  logic [SYNC_W-1:0]                    sync_cnt, sync_n;
  logic [ITERATION_COUNTER_WIDTH-1:0]   iter_n, iter_inc;
  logic                                 timeout_n;
  logic                                 any_processing, any_odd;

  pu_status_reducer #(.PU_COUNT(PU_COUNT)) u_reducer (
    .clk               (clk),
    .reset             (reset),
    .pu_is_processing  (pu_is_processing),
    .pu_is_odd_cluster (pu_is_odd_cluster),
    .any_processing    (any_processing),
    .any_odd           (any_odd)
  );

  // Grow-round counter saturates at the round limit instead of wrapping
  assign iter_inc = (iteration_count >= ITER_MAX)
                    ? iteration_count
                    : iteration_count + ITERATION_COUNTER_WIDTH'(1);

  always_comb begin
    state_n   = state;
    settle_n  = settle;
    sync_n    = sync_cnt;
    iter_n    = iteration_count;
    timeout_n = timeout;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n   = ST_LOAD;
          iter_n    = '0;
          timeout_n = 1'b0;
        end
      end
      ST_LOAD: begin
        state_n = ST_GROW;
        iter_n  = iter_inc;
      end
      ST_GROW: begin
        state_n  = ST_SPREAD;
        settle_n = '0;
      end
      ST_SPREAD: begin
        if (any_processing) begin
          settle_n = '0;
        end else if (settle == SETTLE_LAST) begin
          state_n = ST_SYNC;
          sync_n  = '0;
        end else begin
          settle_n = settle + SETTLE_W'(1);
        end
      end
      ST_SYNC: begin
        if (sync_cnt == SYNC_LAST) begin
          if (!any_odd) begin
            state_n = ST_DONE;
          end else if (iteration_count == ITER_MAX) begin
            state_n   = ST_DONE;
            timeout_n = 1'b1;
          end else begin
            state_n = ST_GROW;
            iter_n  = iter_inc;
          end
        end else begin
          sync_n = sync_cnt + SYNC_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_IDLE;
      settle          <= '0;
      sync_cnt        <= '0;
      stage_out       <= STAGE_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      timeout         <= 1'b0;
      iteration_count <= '0;
    end else begin
      state           <= state_n;
      settle          <= settle_n;
      sync_cnt        <= sync_n;
      stage_out       <= stage_of(state_n);
      busy            <= (state_n == ST_LOAD) || (state_n == ST_GROW) ||
                         (state_n == ST_SPREAD) || (state_n == ST_SYNC);
      done            <= (state_n == ST_DONE);
      timeout         <= timeout_n;
      iteration_count <= iter_n;
    end
  end

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Scoreboard bench for decoder_stage_controller: stimulus pushes expected run
// summaries and stage traces; a negedge monitor pops and compares them.
module tb_decoder_stage_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [99:0] pu_is_processing;
  logic [99:0] pu_is_odd_cluster;
  logic [2:0]  stage_out;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [7:0]  iteration_count;

  decoder_stage_controller dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .pu_is_processing  (pu_is_processing),
    .pu_is_odd_cluster (pu_is_odd_cluster),
    .stage_out         (stage_out),
    .busy              (busy),
    .done              (done),
    .timeout           (timeout),
    .iteration_count   (iteration_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int done_rel;
    int iter;
    int to;
    int grow;
    int busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   stage_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t0 = 0;
  bit   active = 1'b0;
  bit   done_seen = 1'b0;
  int   busy_cnt = 0;
  int   grow_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: compares stage trace per cycle and run summary at done
  always @(negedge clk) begin
    if (active) begin
      int rel;
      rel = cyc - t0;
      if (busy) busy_cnt++;
      if (stage_out == 3'd2) grow_cnt++;
      if (rel >= 1 && stage_q.size() > 0) check("stage_trace", stage_out, stage_q.pop_front());
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_without_expectation", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", rel, e.done_rel);
          check("iteration_count", iteration_count, e.iter);
          check("timeout", timeout, e.to);
          check("grow_stages", grow_cnt, e.grow);
          check("busy_cycles", busy_cnt, e.busy_cycles);
          check("stage_at_done", stage_out, 0);
        end
        active    = 1'b0;
        done_seen = 1'b1;
      end
    end else if (done && !reset) begin
      check("unexpected_done", 1, 0);
    end
  end

  // mode 0 plain, 1 processing burst, 2 odd one round, 3 odd stuck, 4 start re-pulsed
  task automatic run(input int mode, input int d_rel, input int it, input int to,
                     input int gr, input int bc);
    exp_t e;
    e.done_rel = d_rel; e.iter = it; e.to = to; e.grow = gr; e.busy_cycles = bc;
    exp_q.push_back(e);
    if (mode == 0) begin
      int trace[8] = '{4, 2, 1, 1, 1, 3, 3, 0};
      foreach (trace[i]) stage_q.push_back(trace[i]);
    end
    done_seen = 1'b0;
    for (int r = 0; r < 200 && !done_seen; r++) begin
      @(posedge clk); #1;
      if (r == 0) begin
        t0 = cyc; busy_cnt = 0; grow_cnt = 0; active = 1'b1;
      end
      start                 = (r == 0) || (mode == 4 && (r == 3 || r == 6));
      pu_is_processing      = '0;
      pu_is_odd_cluster     = '0;
      pu_is_processing[17]  = (mode == 1) && (r >= 3) && (r <= 6);
      pu_is_odd_cluster[0]  = (mode == 2) && (r <= 7);
      pu_is_odd_cluster[99] = (mode == 3);
    end
    if (!done_seen) begin
      check("done_within_budget", 0, 1);
      active = 1'b0;
    end
    @(posedge clk); #1;
    start = 1'b0; pu_is_processing = '0; pu_is_odd_cluster = '0;
    stage_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pu_is_processing = '0; pu_is_odd_cluster = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stage", stage_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_iter", iteration_count, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run(0, 8, 1, 0, 1, 7);
    run(1, 13, 1, 0, 1, 12);
    run(2, 14, 2, 0, 2, 13);
    run(3, 62, 10, 1, 10, 61);
    repeat (3) @(posedge clk);
    #1;
    check("timeout_held", timeout, 1);
    check("iter_held", iteration_count, 10);
    run(4, 8, 1, 0, 1, 7);
    check("timeout_cleared_next_run", timeout, 0);

    // Reset in the middle of SPREAD
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_reset_stage_spread", stage_out, 1);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("midrst_stage", stage_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_iter", iteration_count, 0);
    check("midrst_timeout", timeout, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_stays_idle", stage_out, 0);

    // Start coincident with reset: reset wins
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1; reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    check("rst_start_stage", stage_out, 0);
    @(posedge clk); #1;
    check("rst_start_still_idle", stage_out, 0);

    run(0, 8, 1, 0, 1, 7);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
